led_sequence_controller: RTL and testbench
==========================================

Name: led_sequence_controller

Overview:
- Sequences the 6-LED bank on the board.
- Owns a step prescaler and a pattern register, and switches between three display modes on a debounced push-button press.
- Replaces a free-running LED counter as the top-level LED driver.
- Drives active-low LEDs directly.

Parameters:
- CLK_TICKS, 13500000, clock cycles per pattern step (0.5 s at 27 MHz); must be >= 2.
- DEBOUNCE, 270000, consecutive stable cycles needed to accept a button level change (10 ms at 27 MHz); must be >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- btn_mode_n_i  input  1  raw mode push-button, active-low, asynchronous to clk.
- run_i  input  1  level; 1 = pattern advances, 0 = pattern frozen.
- led_o  output  6  LED drive, active-low (led_o = ~pat).
- mode_o  output  2  current mode: 0 COUNT, 1 SCAN, 2 BLINK; 3 never driven.
- step_o  output  1  one-cycle pulse in the first cycle a new pattern value is visible on led_o.

Behaviour:
- Reset (rst=1 at a clk edge, overrides everything, including mid-operation):
  - mode = COUNT, pat = 0 (led_o = 6'b111111), scan dir = LEFT.
  - Prescaler = 0, step_o = 0.
  - Both synchronizer flops = 1, debounced state = 1 (released), debounce counter = 0.
- Prescaler:
  - Width $clog2(CLK_TICKS).
  - Increments each cycle while run_i = 1.
  - At CLK_TICKS-1 it asserts internal tick for that cycle and wraps to 0.
  - run_i = 0 holds the count and suppresses tick.
- Button path:
  - 2-flop synchronizer gives s2.
  - Each edge where s2 != debounced state, the counter increments; an edge where they are equal clears it.
  - At the DEBOUNCE-th consecutive differing edge, debounced state <= s2 and the counter clears.
  - Press event = debounced 1->0 transition; it is registered and acts one edge later.
  - Release is debounced identically but causes no action.
  - Latency: low first sampled at edge N gives mode_o change at edge N+DEBOUNCE+3.
- Mode FSM:
  - COUNT -> SCAN -> BLINK -> COUNT, one step per press event.
  - On a mode change, at the same edge: pat <= new mode's initial value, prescaler <= 0, dir <= LEFT, step_o <= 0.
  - If a press event and tick coincide, the mode change wins and the tick is discarded.
  - Mode changes are accepted while run_i = 0.
- Pattern update on tick (next edge):
  - COUNT: init 0; pat <= pat+1 modulo 64 (63 -> 0).
  - SCAN: init 6'b000001.
    - dir LEFT: if pat = 6'b100000 then pat <= 6'b010000, dir <= RIGHT; else pat <= pat<<1.
    - dir RIGHT: if pat = 6'b000001 then pat <= 6'b000010, dir <= LEFT; else pat <= pat>>1.
    - Period is 10 ticks; exactly one bit is set at all times.
  - BLINK: init 0; pat <= ~pat.
- Output timing:
  - step_o is registered and high in the cycle after the tick edge, i.e. coincident with the updated led_o.
  - led_o and mode_o come from registers; no combinational path from inputs.

Test Plan (CLK_TICKS=4, DEBOUNCE=3):
1. Reset, run_i=1, button released:
   - led_o = 111111 and step_o = 0 during reset.
   - step_o pulses every 4 cycles; led_o counts 111110, 111101, ...
   - After 64 steps led_o = 111111 again (wrap).
2. btn held low from edge N:
   - mode_o = 1 at edge N+6; led_o = 111110 and the prescaler restarts.
   - Subsequent steps give pat 000010 .. 100000, 010000 .. 000001, 000010: the bounce with a 10-step period.
3. Glitches of btn low for 1 and 2 cycles, separated by high, with no 3-cycle stable low:
   - mode_o stays 0.
   - A button release (low->high) after a valid press never changes the mode.
4. Two valid presses:
   - mode_o = 2, led_o alternates 111111 / 000000 every 4 cycles.
   - A third press gives mode_o = 0, led_o = 111111.
5. run_i = 0 mid-COUNT at pat = 5: led_o is held at 111010 with no step_o.
   - A press while frozen gives mode_o = 1, led_o = 111110, still held.
   - A press event forced on the same edge as a tick: mode advances, pat = init, step_o = 0.
6. rst=1 for one cycle while in SCAN, dir RIGHT, prescaler mid-count:
   - Next cycle mode_o = 0, led_o = 111111, step_o = 0.
   - The first step arrives 4 cycles after rst deasserts.

Source files
------------

// File: rtl/led_sequence_controller_if.sv
// Pin bundle between the LED sequencer and its board-side driver.
// The driver owns the button and run level; the sequencer owns the LED outputs.
interface led_sequence_controller_if;
  logic       btn_mode_n_i;
  logic       run_i;
  logic [5:0] led_o;
  logic [1:0] mode_o;
  logic       step_o;

  modport master (
    output btn_mode_n_i,
    output run_i,
    input  led_o,
    input  mode_o,
    input  step_o
  );

  modport slave (
    input  btn_mode_n_i,
    input  run_i,
    output led_o,
    output mode_o,
    output step_o
  );
endinterface

// File: rtl/led_sequence_controller.sv
// 6-LED sequencer: step prescaler, debounced mode button and
// COUNT / SCAN / BLINK patterns on active-low LEDs.
module led_sequence_controller #(
  parameter int CLK_TICKS = 13500000,
  parameter int DEBOUNCE  = 270000
) (
  input logic                      clk,
  input logic                      rst,
  led_sequence_controller_if.slave bus
);
  localparam int PW = (CLK_TICKS > 1) ? $clog2(CLK_TICKS) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    COUNT = 2'd0,
    SCAN  = 2'd1,
    BLINK = 2'd2
  } mode_e;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } dir_e;

  mode_e         mode_q, mode_d;
  dir_e          dir_q, dir_d;
  logic [5:0]    pat_q, pat_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          step_q, step_d;
  logic          s1_q, s2_q;
  logic          deb_q, deb_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          prev_q, press_q;
  logic          tick, press;

  assign tick  = bus.run_i & (presc_q == PW'(CLK_TICKS - 1));
  assign press = prev_q & ~deb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= COUNT;
      dir_q   <= LEFT;
      pat_q   <= '0;
      presc_q <= '0;
      step_q  <= 1'b0;
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
      prev_q  <= 1'b1;
      press_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      pat_q   <= pat_d;
      presc_q <= presc_d;
      step_q  <= step_d;
      s1_q    <= bus.btn_mode_n_i;
      s2_q    <= s1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      prev_q  <= deb_q;
      press_q <= press;
    end
  end

  always_comb begin
    mode_d  = mode_q;
    dir_d   = dir_q;
    pat_d   = pat_q;
    presc_d = presc_q;
    step_d  = 1'b0;
    deb_d   = deb_q;
    cnt_d   = '0;

    if (s2_q != deb_q) begin
      if (cnt_q == DW'(DEBOUNCE - 1)) begin
        deb_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // A mode change swallows any tick landing on the same edge.
    if (press_q) begin
      presc_d = '0;
      dir_d   = LEFT;
      unique case (mode_q)
        COUNT: begin
          mode_d = SCAN;
          pat_d  = 6'b000001;
        end
        SCAN: begin
          mode_d = BLINK;
          pat_d  = '0;
        end
        default: begin
          mode_d = COUNT;
          pat_d  = '0;
        end
      endcase
    end else begin
      if (bus.run_i) begin
        presc_d = tick ? '0 : presc_q + 1'b1;
      end
      if (tick) begin
        step_d = 1'b1;
        unique case (mode_q)
          COUNT: pat_d = pat_q + 6'd1;
          SCAN: begin
            if (dir_q == LEFT) begin
              if (pat_q == 6'b100000) begin
                pat_d = 6'b010000;
                dir_d = RIGHT;
              end else begin
                pat_d = pat_q << 1;
              end
            end else begin
              if (pat_q == 6'b000001) begin
                pat_d = 6'b000010;
                dir_d = LEFT;
              end else begin
                pat_d = pat_q >> 1;
              end
            end
          end
          default: pat_d = ~pat_q;
        endcase
      end
    end
  end

  assign bus.led_o  = ~pat_q;
  assign bus.mode_o = mode_q;
  assign bus.step_o = step_q;
endmodule

// File: tb/tb_led_sequence_controller.sv
// Bench for led_sequence_controller against a tick/phase-level model.
module tb_led_sequence_controller;
  localparam int CT = 4;
  localparam int DB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  led_sequence_controller_if bus();

  led_sequence_controller #(
    .CLK_TICKS(CT),
    .DEBOUNCE (DB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // model state: pattern kept as counter / scan phase / blink flag
  int m_mode, m_cnt, m_phase, m_blink;
  int m_presc, m_step;
  int m_s1, m_s2, m_deb, m_mm;
  int m_acts[$];
  int cyc = 0;

  function automatic logic [5:0] exp_led();
    logic [5:0] p;
    int idx;
    p = '0;
    case (m_mode)
      0: p = 6'(m_cnt);
      1: begin
        idx = (m_phase <= 5) ? m_phase : 10 - m_phase;
        p = 6'(1 << idx);
      end
      default: p = m_blink ? 6'h3f : 6'h00;
    endcase
    return ~p;
  endfunction

  function automatic logic [5:0] init_led(input int md);
    return (md == 1) ? 6'b111110 : 6'b111111;
  endfunction

  task automatic model_edge();
    bit act, tck;
    cyc++;
    if (rst) begin
      m_mode = 0; m_cnt = 0; m_phase = 0; m_blink = 0;
      m_presc = 0; m_step = 0;
      m_s1 = 1; m_s2 = 1; m_deb = 1; m_mm = 0;
      m_acts.delete();
      return;
    end
    act = (m_acts.size() > 0) && (m_acts[0] == cyc);
    if (act) void'(m_acts.pop_front());
    tck = bus.run_i && (m_presc == CT - 1);
    if (act) begin
      m_mode = (m_mode + 1) % 3;
      m_cnt = 0; m_phase = 0; m_blink = 0;
      m_presc = 0; m_step = 0;
    end else begin
      m_step = tck;
      if (bus.run_i) m_presc = (m_presc + 1) % CT;
      if (tck) begin
        case (m_mode)
          0: m_cnt = (m_cnt + 1) % 64;
          1: m_phase = (m_phase + 1) % 10;
          default: m_blink = !m_blink;
        endcase
      end
    end
    if (m_s2 != m_deb) begin
      m_mm++;
      if (m_mm == DB) begin
        if (m_deb == 1) m_acts.push_back(cyc + 2);
        m_deb = m_s2;
        m_mm = 0;
      end
    end else begin
      m_mm = 0;
    end
    m_s2 = m_s1;
    m_s1 = int'(bus.btn_mode_n_i);
  endtask

  task automatic clk_n(input int n);
    logic [8:0] got, exp;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      got = {bus.mode_o, bus.step_o, bus.led_o};
      exp = {2'(m_mode), 1'(m_step), exp_led()};
      n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL track cyc=%0d got mode=%0d step=%b led=%b want mode=%0d step=%b led=%b",
                 cyc, got[8:7], got[6], got[5:0], exp[8:7], exp[6], exp[5:0]);
      end
    end
  endtask

  task automatic press();
    bus.btn_mode_n_i = 1'b0;
    clk_n(8);
    bus.btn_mode_n_i = 1'b1;
    clk_n(8);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clk_n(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.btn_mode_n_i = 1'b1;
    bus.run_i = 1'b1;
    rst = 1'b1;
    clk_n(3);
    n_chk++;
    if (bus.led_o !== 6'h3f || bus.step_o !== 1'b0 || bus.mode_o !== 2'd0) begin
      n_fail++;
      $display("FAIL reset led=%b step=%b mode=%0d want 111111/0/0",
               bus.led_o, bus.step_o, bus.mode_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_count_wrap();
    int steps = 0;
    for (int i = 0; i < 64 * CT + 2; i++) begin
      clk_n(1);
      if (bus.step_o) begin
        steps++;
        if (steps == 1) begin
          n_chk++;
          if (bus.led_o !== 6'b111110) begin
            n_fail++;
            $display("FAIL count_first led=%b want 111110", bus.led_o);
          end
        end
        if (steps == 64) begin
          n_chk++;
          if (bus.led_o !== 6'h3f) begin
            n_fail++;
            $display("FAIL count_wrap led=%b want 111111", bus.led_o);
          end
        end
      end
    end
    n_chk++;
    if (steps != 64) begin
      n_fail++;
      $display("FAIL count_steps got %0d want 64", steps);
    end
  endtask

  task automatic test_scan();
    bus.btn_mode_n_i = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      clk_n(1);
      if (k == 5) begin
        n_chk++;
        if (bus.mode_o !== 2'd0) begin
          n_fail++;
          $display("FAIL scan_early mode=%0d want 0", bus.mode_o);
        end
      end
    end
    n_chk++;
    if (bus.mode_o !== 2'd1 || bus.led_o !== 6'b111110) begin
      n_fail++;
      $display("FAIL scan_enter mode=%0d led=%b want 1/111110",
               bus.mode_o, bus.led_o);
    end
    clk_n(4);
    bus.btn_mode_n_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      clk_n(1);
      n_chk++;
      if ($countones(bus.led_o) != 5 || bus.mode_o !== 2'd1) begin
        n_fail++;
        $display("FAIL scan_onehot led=%b mode=%0d want one lit, mode 1",
                 bus.led_o, bus.mode_o);
      end
    end
  endtask

  task automatic test_glitch();
    logic [1:0] m0;
    m0 = bus.mode_o;
    for (int g = 0; g < 12; g++) begin
      bus.btn_mode_n_i = 1'b0;
      clk_n(int'($urandom_range(1, DB - 1)));
      bus.btn_mode_n_i = 1'b1;
      clk_n(int'($urandom_range(1, 3)));
    end
    clk_n(8);
    n_chk++;
    if (bus.mode_o !== m0) begin
      n_fail++;
      $display("FAIL glitch mode=%0d want %0d", bus.mode_o, m0);
    end
  endtask

  task automatic test_blink();
    logic [5:0] last;
    do_reset();
    press();
    press();
    n_chk++;
    if (bus.mode_o !== 2'd2) begin
      n_fail++;
      $display("FAIL blink_mode mode=%0d want 2", bus.mode_o);
    end
    last = bus.led_o;
    for (int i = 0; i < 24; i++) begin
      clk_n(1);
      if (bus.step_o) begin
        n_chk++;
        if (bus.led_o !== ~last || (bus.led_o !== 6'h3f && bus.led_o !== 6'h00)) begin
          n_fail++;
          $display("FAIL blink_toggle led=%b want %b", bus.led_o, ~last);
        end
        last = bus.led_o;
      end
    end
    bus.btn_mode_n_i = 1'b0;
    clk_n(7);
    n_chk++;
    if (bus.mode_o !== 2'd0 || bus.led_o !== 6'h3f) begin
      n_fail++;
      $display("FAIL blink_wrap mode=%0d led=%b want 0/111111",
               bus.mode_o, bus.led_o);
    end
    clk_n(1);
    bus.btn_mode_n_i = 1'b1;
    clk_n(8);
  endtask

  task automatic test_freeze();
    int guard = 0;
    do_reset();
    bus.run_i = 1'b1;
    while (!(m_cnt == 5 && m_step == 1) && guard < 200) begin
      clk_n(1);
      guard++;
    end
    n_chk++;
    if (guard >= 200) begin
      n_fail++;
      $display("FAIL freeze_wait timeout got cnt=%0d want 5", m_cnt);
    end
    bus.run_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      clk_n(1);
      n_chk++;
      if (bus.led_o !== 6'b111010 || bus.step_o !== 1'b0) begin
        n_fail++;
        $display("FAIL freeze_hold led=%b step=%b want 111010/0",
                 bus.led_o, bus.step_o);
      end
    end
    press();
    for (int i = 0; i < 10; i++) begin
      clk_n(1);
      n_chk++;
      if (bus.mode_o !== 2'd1 || bus.led_o !== 6'b111110 || bus.step_o !== 1'b0) begin
        n_fail++;
        $display("FAIL freeze_press mode=%0d led=%b step=%b want 1/111110/0",
                 bus.mode_o, bus.led_o, bus.step_o);
      end
    end
  endtask

  task automatic test_coincide();
    int guard = 0;
    int m0;
    bus.run_i = 1'b1;
    clk_n(1);
    while (m_presc != 1 && guard < 10) begin
      clk_n(1);
      guard++;
    end
    m0 = m_mode;
    bus.btn_mode_n_i = 1'b0;
    clk_n(6);
    n_chk++;
    if (m_presc != CT - 1) begin
      n_fail++;
      $display("FAIL coincide_align presc=%0d want %0d", m_presc, CT - 1);
    end
    clk_n(1);
    n_chk++;
    if (bus.mode_o !== 2'((m0 + 1) % 3) || bus.step_o !== 1'b0 ||
        bus.led_o !== init_led((m0 + 1) % 3)) begin
      n_fail++;
      $display("FAIL coincide mode=%0d step=%b led=%b want %0d/0/%b",
               bus.mode_o, bus.step_o, bus.led_o, (m0 + 1) % 3,
               init_led((m0 + 1) % 3));
    end
    bus.btn_mode_n_i = 1'b1;
    clk_n(8);
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    do_reset();
    bus.run_i = 1'b1;
    press();
    while (!(m_mode == 1 && m_phase >= 6 && m_presc == 2) && guard < 200) begin
      clk_n(1);
      guard++;
    end
    n_chk++;
    if (guard >= 200) begin
      n_fail++;
      $display("FAIL rstmid_wait timeout got phase=%0d want >=6", m_phase);
    end
    rst = 1'b1;
    clk_n(1);
    rst = 1'b0;
    n_chk++;
    if (bus.mode_o !== 2'd0 || bus.led_o !== 6'h3f || bus.step_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid mode=%0d led=%b step=%b want 0/111111/0",
               bus.mode_o, bus.led_o, bus.step_o);
    end
    for (int i = 1; i <= 4; i++) begin
      clk_n(1);
      n_chk++;
      if (bus.step_o !== (i == 4)) begin
        n_fail++;
        $display("FAIL rstmid_step cyc%0d step=%b want %b", i, bus.step_o, i == 4);
      end
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 250; s++) begin
      bus.btn_mode_n_i = 1'($urandom_range(0, 1));
      bus.run_i = ($urandom_range(0, 9) != 0);
      clk_n(int'($urandom_range(1, 12)));
    end
    bus.btn_mode_n_i = 1'b1;
    clk_n(10);
  endtask

  initial begin
    bus.btn_mode_n_i = 1'b1;
    bus.run_i = 1'b1;
    test_reset();
    test_count_wrap();
    test_scan();
    test_glitch();
    test_blink();
    test_glitch();
    test_freeze();
    test_coincide();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
